snake_collision_scanner: RTL and testbench

SNAKE_COLLISION_SCANNER -- requirements
Module: snake_collision_scanner

---
 rtl/snake_collision_scanner_pkg.sv | 26 ++
 rtl/square_overlap.sv | 25 ++
 rtl/snake_collision_scanner.sv | 181 ++++++++++++++++++
 tb/tb_snake_collision_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_collision_scanner_pkg.sv
// Shared definitions for the snake game blocks: FSM state encoding,
// playfield geometry defaults and a length clamp helper.
package snake_collision_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int MAX_LEN_DEF = 16;
    localparam int DIM_DEF     = 10;
    localparam int XSCREEN_DEF = 160;
    localparam int YSCREEN_DEF = 120;

    function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] cap);
        if (len > cap) begin
            return cap;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/square_overlap.sv
// One-axis overlap test for two DIM-sized squares: |a-b| < DIM,
// evaluated at 9 bits so the difference never wraps.
module square_overlap
    import snake_collision_scanner_pkg::*;
#(
    parameter int DIM = DIM_DEF
) (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic       overlap
);

    logic [8:0] diff_s;

    // Absolute difference and threshold compare
    always_comb begin
        if (a >= b) begin
            diff_s = a - b;
        end else begin
            diff_s = b - a;
        end
        overlap = (diff_s < 9'(DIM));
    end

endmodule

// File: rtl/snake_collision_scanner.sv
// Scans a snapshot of the snake for wall, self and apple collisions,
// comparing one body segment per clock after a single head check.
module snake_collision_scanner
    import snake_collision_scanner_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int DIM     = DIM_DEF,
    parameter int XSCREEN = XSCREEN_DEF,
    parameter int YSCREEN = YSCREEN_DEF
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [4:0]             length,
    input  logic [8*MAX_LEN-1:0]   x_body,
    input  logic [7*MAX_LEN-1:0]   y_body,
    input  logic [7:0]             apple_x,
    input  logic [6:0]             apple_y,
    output logic                   busy,
    output logic                   done,
    output logic                   hit_wall,
    output logic                   hit_self,
    output logic                   hit_apple
);

    localparam logic [7:0] X_LIMIT = 8'(XSCREEN - DIM);
    localparam logic [6:0] Y_LIMIT = 7'(YSCREEN - DIM);

    state_t               state_r;
    state_t               state_s;
    logic                 busy_r;
    logic                 done_r;
    logic                 busy_s;
    logic                 done_s;
    logic                 hit_wall_r;
    logic                 hit_self_r;
    logic                 hit_apple_r;
    logic [4:0]           len_r;
    logic [4:0]           idx_r;
    logic [8*MAX_LEN-1:0] x_snap_r;
    logic [7*MAX_LEN-1:0] y_snap_r;
    logic [7:0]           apple_x_r;
    logic [6:0]           apple_y_r;
    logic [7:0]           head_x_s;
    logic [6:0]           head_y_s;
    logic [7:0]           seg_x_s;
    logic [6:0]           seg_y_s;
    logic                 seg_match_s;
    logic                 last_s;
    logic                 ov_x_s;
    logic                 ov_y_s;

    assign head_x_s = x_snap_r[7:0];
    assign head_y_s = y_snap_r[6:0];

    square_overlap #(.DIM(DIM)) u_apple_x (
        .a       ({1'b0, head_x_s}),
        .b       ({1'b0, apple_x_r}),
        .overlap (ov_x_s)
    );

    square_overlap #(.DIM(DIM)) u_apple_y (
        .a       ({2'b00, head_y_s}),
        .b       ({2'b00, apple_y_r}),
        .overlap (ov_y_s)
    );

    // Segment selected by idx; AND-OR mux keeps every index constant
    always_comb begin
        seg_x_s = 8'd0;
        seg_y_s = 7'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_s = seg_x_s | (x_snap_r[8*i +: 8] & {8{idx_r == 5'(i)}});
            seg_y_s = seg_y_s | (y_snap_r[7*i +: 7] & {7{idx_r == 5'(i)}});
        end
        seg_match_s = (seg_x_s == head_x_s) && (seg_y_s == head_y_s);
        last_s      = (idx_r == (len_r - 5'd1));
    end

    // FSM state and registered status outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_s = ST_CHECK;
            ST_CHECK: begin
                if (len_r >= 5'd2) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_SCAN: begin
                if (seg_match_s || last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Status outputs follow the state being entered, so they register in step with it
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // Snapshot, segment index and collision result registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            len_r       <= 5'd0;
            idx_r       <= 5'd0;
            x_snap_r    <= '0;
            y_snap_r    <= '0;
            apple_x_r   <= 8'd0;
            apple_y_r   <= 7'd0;
            hit_wall_r  <= 1'b0;
            hit_self_r  <= 1'b0;
            hit_apple_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    len_r       <= clamp_len(length, 5'(MAX_LEN));
                    idx_r       <= 5'd1;
                    x_snap_r    <= x_body;
                    y_snap_r    <= y_body;
                    apple_x_r   <= apple_x;
                    apple_y_r   <= apple_y;
                    hit_wall_r  <= 1'b0;
                    hit_self_r  <= 1'b0;
                    hit_apple_r <= 1'b0;
                end
                ST_CHECK: begin
                    hit_wall_r  <= (head_x_s > X_LIMIT) || (head_y_s > Y_LIMIT);
                    hit_apple_r <= ov_x_s && ov_y_s;
                end
                ST_SCAN: begin
                    if (seg_match_s) begin
                        hit_self_r <= 1'b1;
                    end else if (!last_s) begin
                        idx_r <= idx_r + 5'd1;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign hit_wall  = hit_wall_r;
    assign hit_self  = hit_self_r;
    assign hit_apple = hit_apple_r;

endmodule

// File: tb/tb_snake_collision_scanner.sv
// Self-checking bench for snake_collision_scanner: directed vector table,
// randomized scans against a reference model, and multi-cycle corner cases.
module tb_snake_collision_scanner;

    localparam int ML = 16;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic [4:0]     length = 5'd0;
    logic [8*ML-1:0] x_body = '0;
    logic [7*ML-1:0] y_body = '0;
    logic [7:0]     apple_x = 8'd0;
    logic [6:0]     apple_y = 7'd0;
    logic           busy, done, hit_wall, hit_self, hit_apple;

    int total = 0;
    int bad   = 0;

    snake_collision_scanner #(.MAX_LEN(ML), .DIM(10), .XSCREEN(160), .YSCREEN(120)) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .length    (length),
        .x_body    (x_body),
        .y_body    (y_body),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .busy      (busy),
        .done      (done),
        .hit_wall  (hit_wall),
        .hit_self  (hit_self),
        .hit_apple (hit_apple)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    len;
        int    hx;
        int    hy;
        int    ax;
        int    ay;
        int    dup;
        int    ew;
        int    es;
        int    ea;
        int    elat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Body is a vertical line below the head; segment dup (if nonzero) sits on the head
    task automatic build(input int hx, input int hy, input int dup,
                         output logic [8*ML-1:0] xb, output logic [7*ML-1:0] yb);
        xb = '0;
        yb = '0;
        for (int i = 0; i < ML; i++) begin
            xb[8*i +: 8] = 8'(hx);
            yb[7*i +: 7] = 7'((hy + 10 * i) % 128);
        end
        if (dup > 0) yb[7*dup +: 7] = 7'(hy);
    endtask

    // Reference: scan rules expressed directly on integers
    function automatic void ref_scan(input int len, input logic [8*ML-1:0] xb, input logic [7*ML-1:0] yb,
                                     input int ax, input int ay,
                                     output int w, output int s, output int a, output int lat);
        int eff, hx, hy, dx, dy;
        eff = (len > ML) ? ML : len;
        if (eff < 1) eff = 1;
        hx = int'(xb[7:0]);
        hy = int'(yb[6:0]);
        dx = (hx > ax) ? hx - ax : ax - hx;
        dy = (hy > ay) ? hy - ay : ay - hy;
        w = (hx > 150 || hy > 110) ? 1 : 0;
        a = (dx < 10 && dy < 10) ? 1 : 0;
        s = 0;
        lat = eff + 2;
        for (int i = 1; i < eff; i++) begin
            if (s == 0 && int'(xb[8*i +: 8]) == hx && int'(yb[7*i +: 7]) == hy) begin
                s = 1;
                lat = i + 3;
            end
        end
    endfunction

    task automatic run_scan(input string name, input int len, input logic [8*ML-1:0] xb,
                            input logic [7*ML-1:0] yb, input int ax, input int ay,
                            input int ew, input int es, input int ea, input int elat);
        int done_cyc, ndone, busy_err, w, s, a;
        done_cyc = -1; ndone = 0; busy_err = 0; w = 0; s = 0; a = 0;
        @(negedge clk);
        length  = 5'(len);
        x_body  = xb;
        y_body  = yb;
        apple_x = 8'(ax);
        apple_y = 7'(ay);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    w = int'(hit_wall);
                    s = int'(hit_self);
                    a = int'(hit_apple);
                end
            end
            if (busy !== ((c <= elat) ? 1'b1 : 1'b0)) busy_err++;
            @(posedge clk);
            #1;
        end
        check({name, " done_cycle"}, 32'(done_cyc), 32'(elat));
        check({name, " done_count"}, 32'(ndone), 32'd1);
        check({name, " busy_profile_errs"}, 32'(busy_err), 32'd0);
        check({name, " hit_wall"}, 32'(w), 32'(ew));
        check({name, " hit_self"}, 32'(s), 32'(es));
        check({name, " hit_apple"}, 32'(a), 32'(ea));
        check({name, " hits_held"}, {29'd0, hit_wall, hit_self, hit_apple}, 32'((ew << 2) | (es << 1) | ea));
    endtask

    vec_t vecs[13];

    initial begin
        logic [8*ML-1:0] xb;
        logic [7*ML-1:0] yb;
        logic [127:0]    rnd;
        int len, ax, ay, w, s, a, lat, k, done_seen, busy_seen;
        int dcyc[$];
        int self_at_done[$];

        vecs[0]  = '{"basic_l4",    4,  80,  60, 30, 30, 0, 0, 0, 0, 6};
        vecs[1]  = '{"self_seg2",   4,  80,  70, 30, 30, 2, 0, 1, 0, 5};
        vecs[2]  = '{"wall_x151",   1, 151,  60, 30, 30, 0, 1, 0, 0, 3};
        vecs[3]  = '{"wall_x250",   1, 250,  60, 30, 30, 0, 1, 0, 0, 3};
        vecs[4]  = '{"apple_in",    1,  39,  21, 30, 30, 0, 0, 0, 1, 3};
        vecs[5]  = '{"apple_edge",  1,  40,  30, 30, 30, 0, 0, 0, 0, 3};
        vecs[6]  = '{"len0",        0,  80,  60, 30, 30, 0, 0, 0, 0, 3};
        vecs[7]  = '{"wall_limit",  2, 150, 110, 30, 30, 0, 0, 0, 0, 4};
        vecs[8]  = '{"wall_y111",   2,  80, 111, 30, 30, 0, 1, 0, 0, 4};
        vecs[9]  = '{"self_last",  16,  80,  60, 30, 30, 15, 0, 1, 0, 18};
        vecs[10] = '{"len_clamp",  20,  80,  60, 30, 30, 0, 0, 0, 0, 18};
        vecs[11] = '{"self_seg1",  31,  80,  60, 30, 30, 1, 0, 1, 0, 4};
        vecs[12] = '{"apple_ydist", 3, 21,   20, 30, 30, 0, 0, 0, 0, 5};

        // Reset state, held low across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, busy, done, hit_wall, hit_self, hit_apple}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", {27'd0, busy, done, hit_wall, hit_self, hit_apple}, 32'd0);

        foreach (vecs[i]) begin
            build(vecs[i].hx, vecs[i].hy, vecs[i].dup, xb, yb);
            run_scan(vecs[i].name, vecs[i].len, xb, yb, vecs[i].ax, vecs[i].ay,
                     vecs[i].ew, vecs[i].es, vecs[i].ea, vecs[i].elat);
        end

        // Randomized scans against the reference model
        for (int n = 0; n < 150; n++) begin
            len = $urandom_range(0, 31);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            xb  = rnd;
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            yb  = rnd[7*ML-1:0];
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, ML - 1);
                xb[8*k +: 8] = xb[7:0];
                yb[7*k +: 7] = yb[6:0];
            end
            ax = (int'(xb[7:0]) + $urandom_range(0, 24) + 244) % 256;
            ay = (int'(yb[6:0]) + $urandom_range(0, 24) + 116) % 128;
            ref_scan(len, xb, yb, ax, ay, w, s, a, lat);
            run_scan("random", len, xb, yb, ax, ay, w, s, a, lat);
        end

        // Start held high; body rewritten mid-scan so only the next scan sees it
        build(80, 60, 0, xb, yb);
        @(negedge clk);
        length = 5'd4; x_body = xb; y_body = yb; apple_x = 8'd30; apple_y = 7'd30;
        start = 1'b1;
        @(posedge clk);
        #1;
        busy_seen = 0;
        for (int c = 1; c <= 14; c++) begin
            if (done === 1'b1) begin
                dcyc.push_back(c);
                self_at_done.push_back(int'(hit_self));
            end
            if (c == 7) busy_seen = int'(busy);
            @(negedge clk);
            if (c == 3) begin
                for (int i = 0; i < ML; i++) begin
                    x_body[8*i +: 8] = 8'd80;
                    y_body[7*i +: 7] = 7'd60;
                end
            end
            if (c == 12) start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("hold_done_count", 32'(dcyc.size()), 32'd2);
        if (dcyc.size() == 2) begin
            check("hold_first_done", 32'(dcyc[0]), 32'd6);
            check("hold_first_self", 32'(self_at_done[0]), 32'd0);
            check("hold_second_done", 32'(dcyc[1]), 32'd11);
            check("hold_second_self", 32'(self_at_done[1]), 32'd1);
        end
        check("hold_idle_gap_busy", 32'(busy_seen), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_released_idle", {30'd0, busy, done}, 32'd0);

        // Reset pulsed during SCAN: immediate clear, no done, then normal operation
        build(200, 60, 0, xb, yb);
        @(negedge clk);
        length = 5'd8; x_body = xb; y_body = yb; apple_x = 8'd200; apple_y = 7'd60;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_scan_state", {29'd0, busy, hit_wall, hit_apple}, 32'd7);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("reset_async_clear", {27'd0, busy, done, hit_wall, hit_self, hit_apple}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_clear", {27'd0, busy, done, hit_wall, hit_self, hit_apple}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        build(80, 60, 0, xb, yb);
        run_scan("after_reset", 4, xb, yb, 30, 30, 0, 0, 0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
